// File: rtl/stream_arb_pkg.sv
// Shared types and constants for the stream round-robin arbiter.
package stream_arb_pkg;

    localparam int BEAT_CNT_W = 8;
    localparam int STATS_W    = 16;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Round-robin search: first set request at or above ptr, wrapping at N.
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic                 any,
    output logic [$clog2(N)-1:0] idx
);

    localparam int IW = $clog2(N);

    logic          hit;
    int            p;
    logic [IW-1:0] pi;

    always_comb begin
        hit = 1'b0;
        idx = '0;
        p   = 0;
        pi  = '0;
        for (int j = 0; j < N; j++) begin
            p = int'(ptr) + j;
            if (p >= N) p = p - N;
            pi = IW'(p);
            if (!hit && req[pi]) begin
                hit = 1'b1;
                idx = pi;
            end
        end
        any = hit;
    end

endmodule

// File: rtl/stream_rr_arb.sv
// N-to-1 stream arbiter with round-robin grants of up to BURST beats.
// Optional per-requester beat counters under STREAM_RR_ARB_STATS_EN.
module stream_rr_arb
    import stream_arb_pkg::*;
#(
    parameter int W     = 16,
    parameter int N     = 4,
    parameter int BURST = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N*W-1:0]       s_data,
    input  logic [N-1:0]         s_valid,
    output logic [N-1:0]         s_ready,
    output logic [W-1:0]         m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [$clog2(N)-1:0] m_id
`ifdef STREAM_RR_ARB_STATS_EN
    ,
    input  logic                 stats_clr,
    output logic [N*16-1:0]      stats_beats
`endif
);

    localparam int IW = $clog2(N);

    arb_state_e            state, state_nx;
    logic [IW-1:0]         g, g_nx;
    logic [IW-1:0]         rr_ptr, ptr_nx;
    logic [BEAT_CNT_W-1:0] cnt, cnt_nx;

    logic [IW-1:0] g_inc;
    logic [N-1:0]  others;
    logic          idle_any, next_any;
    logic [IW-1:0] idle_idx, next_idx;
    logic          xfer;

    assign g_inc = (g == IW'(N - 1)) ? '0 : g + 1'b1;

    always_comb begin
        others    = s_valid;
        others[g] = 1'b0;
    end

    rr_pick #(.N(N)) u_idle_pick (
        .req (s_valid),
        .ptr (rr_ptr),
        .any (idle_any),
        .idx (idle_idx)
    );

    // Regrant search skips the current owner so it cannot win twice in a row
    rr_pick #(.N(N)) u_next_pick (
        .req (others),
        .ptr (g_inc),
        .any (next_any),
        .idx (next_idx)
    );

    assign xfer = (state == BUSY) && s_valid[g] && m_ready;

    always_comb begin
        m_valid = 1'b0;
        m_data  = '0;
        m_id    = '0;
        s_ready = '0;
        if (state == BUSY) begin
            m_valid    = s_valid[g];
            m_data     = s_data[g*W +: W];
            m_id       = g;
            s_ready[g] = m_ready;
        end
    end

    always_comb begin
        state_nx = state;
        g_nx     = g;
        cnt_nx   = cnt;
        ptr_nx   = rr_ptr;
        unique case (state)
            IDLE: begin
                if (idle_any) begin
                    state_nx = BUSY;
                    g_nx     = idle_idx;
                    cnt_nx   = '0;
                end
            end
            BUSY: begin
                if (!s_valid[g]) begin
                    state_nx = IDLE;
                    ptr_nx   = g_inc;
                end else if (m_ready) begin
                    if (cnt == BEAT_CNT_W'(BURST - 1)) begin
                        ptr_nx = g_inc;
                        cnt_nx = '0;
                        if (next_any) g_nx = next_idx;
                        else state_nx = IDLE;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            g      <= '0;
            cnt    <= '0;
            rr_ptr <= '0;
        end else begin
            state  <= state_nx;
            g      <= g_nx;
            cnt    <= cnt_nx;
            rr_ptr <= ptr_nx;
        end
    end

`ifdef STREAM_RR_ARB_STATS_EN
    for (genvar i = 0; i < N; i++) begin : g_stats
        logic [STATS_W-1:0] beats;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                beats <= '0;
            end else if (stats_clr) begin
                beats <= '0;
            end else if (xfer && g == IW'(i) && beats != '1) begin
                beats <= beats + 1'b1;
            end
        end

        assign stats_beats[i*16 +: 16] = beats;
    end
`endif

endmodule

// File: tb/tb_stream_rr_arb.sv
// Bench for stream_rr_arb: three DUTs (BURST 4/2/1) against a
// behavioural model, with literal pins of the model traces.
module tb_stream_rr_arb;

    localparam int N = 4;
    localparam int W = 16;
    localparam int K = 3;
    localparam int TMAX = 32;

    logic clk;
    logic rst_n;
    logic mr;

    logic [N*W-1:0] sd  [K];
    logic [N-1:0]   sv  [K];
    logic [N-1:0]   sr  [K];
    logic [W-1:0]   md  [K];
    logic           mv  [K];
    logic [1:0]     mid [K];

`ifdef STREAM_RR_ARB_STATS_EN
    logic [N*16-1:0] st [K];
    logic [N*W-1:0]  sd_s;
    logic [N-1:0]    sv_s;
    logic [N-1:0]    sr_s;
    logic [W-1:0]    md_s;
    logic            mv_s;
    logic [1:0]      mid_s;
    logic            clr_s;
    logic [N*16-1:0] st_s;
    int              mst [K][N];
`endif

    int burst [K] = '{4, 2, 1};

    // model state per DUT
    int busy [K], g [K], cnt [K], ptr [K];
    int nb [K], ng [K], nc [K], np [K], xf [K];
    // bench-side sources
    int rem [K][N];
    int seq [K][N];
    // traces of model outputs
    int tv [K][TMAX], tid [K][TMAX], tx [K][TMAX], tdat [K][TMAX];
    int t;

    int n_cmp = 0;
    int n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    stream_rr_arb #(.W(W), .N(N), .BURST(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .s_data(sd[0]), .s_valid(sv[0]),
        .s_ready(sr[0]), .m_data(md[0]), .m_valid(mv[0]),
        .m_ready(mr), .m_id(mid[0])
`ifdef STREAM_RR_ARB_STATS_EN
        , .stats_clr(1'b0), .stats_beats(st[0])
`endif
    );

    stream_rr_arb #(.W(W), .N(N), .BURST(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .s_data(sd[1]), .s_valid(sv[1]),
        .s_ready(sr[1]), .m_data(md[1]), .m_valid(mv[1]),
        .m_ready(mr), .m_id(mid[1])
`ifdef STREAM_RR_ARB_STATS_EN
        , .stats_clr(1'b0), .stats_beats(st[1])
`endif
    );

    stream_rr_arb #(.W(W), .N(N), .BURST(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .s_data(sd[2]), .s_valid(sv[2]),
        .s_ready(sr[2]), .m_data(md[2]), .m_valid(mv[2]),
        .m_ready(mr), .m_id(mid[2])
`ifdef STREAM_RR_ARB_STATS_EN
        , .stats_clr(1'b0), .stats_beats(st[2])
`endif
    );

`ifdef STREAM_RR_ARB_STATS_EN
    stream_rr_arb #(.W(W), .N(N), .BURST(255)) dut_s (
        .clk(clk), .rst_n(rst_n), .s_data(sd_s), .s_valid(sv_s),
        .s_ready(sr_s), .m_data(md_s), .m_valid(mv_s),
        .m_ready(1'b1), .m_id(mid_s),
        .stats_clr(clr_s), .stats_beats(st_s)
    );
`endif

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s t=%0t: got %0h, expected %0h",
                     name, $time, act, exp);
        end
    endtask

    function automatic int vmask(input int k);
        int m;
        m = 0;
        for (int i = 0; i < N; i++)
            if (rem[k][i] > 0) m |= (1 << i);
        return m;
    endfunction

    function automatic int search(input int m, input int from);
        for (int j = 0; j < N; j++) begin
            int idx;
            idx = (from + j) % N;
            if (((m >> idx) & 1) == 1) return idx;
        end
        return -1;
    endfunction

    task automatic drive();
        for (int k = 0; k < K; k++)
            for (int i = 0; i < N; i++) begin
                sv[k][i] = (rem[k][i] > 0);
                sd[k][i*W +: W] = 16'(i * 4096 + seq[k][i]);
            end
    endtask

    task automatic eval();
        for (int k = 0; k < K; k++) begin
            int ev, ed, eid, esr, x, vm, oth;
            ev = 0; ed = 0; eid = 0; esr = 0; x = 0;
            vm = vmask(k);
            nb[k] = busy[k]; ng[k] = g[k];
            nc[k] = cnt[k];  np[k] = ptr[k];
            if (!rst_n) begin
                nb[k] = 0; ng[k] = 0; nc[k] = 0; np[k] = 0;
`ifdef STREAM_RR_ARB_STATS_EN
                for (int i = 0; i < N; i++) mst[k][i] = 0;
`endif
            end else if (busy[k] == 0) begin
                if (vm != 0) begin
                    nb[k] = 1;
                    ng[k] = search(vm, ptr[k]);
                    nc[k] = 0;
                end
            end else begin
                ev  = (rem[k][g[k]] > 0) ? 1 : 0;
                ed  = g[k] * 4096 + seq[k][g[k]];
                eid = g[k];
                esr = mr ? (1 << g[k]) : 0;
                if (ev == 0) begin
                    nb[k] = 0;
                    np[k] = (g[k] + 1) % N;
                end else if (mr) begin
                    x = 1;
                    if (cnt[k] + 1 == burst[k]) begin
                        np[k] = (g[k] + 1) % N;
                        nc[k] = 0;
                        oth = vm & ~(1 << g[k]);
                        if (oth != 0) ng[k] = search(oth, (g[k] + 1) % N);
                        else nb[k] = 0;
                    end else begin
                        nc[k] = cnt[k] + 1;
                    end
                end
            end
            chk($sformatf("d%0d m_valid", k), int'(mv[k]), ev);
            chk($sformatf("d%0d m_data", k), int'(md[k]), ed);
            chk($sformatf("d%0d m_id", k), int'(mid[k]), eid);
            chk($sformatf("d%0d s_ready", k), int'(sr[k]), esr);
`ifdef STREAM_RR_ARB_STATS_EN
            for (int i = 0; i < N; i++)
                chk($sformatf("d%0d stats%0d", k, i),
                    int'(st[k][i*16 +: 16]), mst[k][i]);
`endif
            xf[k] = x;
            if (t < TMAX) begin
                tv[k][t] = ev; tid[k][t] = eid;
                tx[k][t] = x;  tdat[k][t] = ed;
            end
        end
    endtask

    task automatic commit();
        for (int k = 0; k < K; k++) begin
            if (xf[k] == 1) begin
                rem[k][g[k]]--;
                seq[k][g[k]]++;
`ifdef STREAM_RR_ARB_STATS_EN
                if (mst[k][g[k]] < 65535) mst[k][g[k]]++;
`endif
            end
            busy[k] = nb[k]; g[k] = ng[k];
            cnt[k] = nc[k];  ptr[k] = np[k];
        end
        drive();
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            eval();
            t++;
            @(posedge clk);
            #1;
            commit();
        end
    endtask

    task automatic clear_src();
        for (int k = 0; k < K; k++)
            for (int i = 0; i < N; i++) begin
                rem[k][i] = 0;
                seq[k][i] = 0;
            end
        drive();
    endtask

    task automatic load(input int i, input int n);
        for (int k = 0; k < K; k++) rem[k][i] = n;
        drive();
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        clear_src();
        step(1);
        rst_n = 1'b1;
        t = 0;
    endtask

    initial begin
        int ex_a [16] = '{0,1,1,1,1,0,1,1,1,1,0,1,1,0,0,0};
        int ex_b1 [10] = '{0,0,1,1,2,2,3,3,0,0};
        int ex_b2 [8] = '{0,1,2,3,0,1,2,3};
        int ex_cv [7] = '{0,1,1,0,0,1,1};
        int ex_d [13] = '{0,1,1,0,0,0,0,0,1,1,0,1,1};

        for (int k = 0; k < K; k++) begin
            busy[k] = 0; g[k] = 0; cnt[k] = 0; ptr[k] = 0; xf[k] = 0;
`ifdef STREAM_RR_ARB_STATS_EN
            for (int i = 0; i < N; i++) mst[k][i] = 0;
`endif
        end
`ifdef STREAM_RR_ARB_STATS_EN
        sv_s = '0; sd_s = '0; clr_s = 1'b0;
`endif
        t = 0;
        mr = 1'b1;
        rst_n = 1'b0;
        clear_src();
        step(2);
        rst_n = 1'b1;
        t = 0;

        // single requester, 10 beats
        load(0, 10);
        step(16);
        for (int c = 0; c < 16; c++)
            chk($sformatf("A xfer c%0d", c), tx[0][c], ex_a[c]);
        chk("A first data", tdat[0][1], 16'h0000);
        chk("A last data", tdat[0][12], 16'h0009);

        // all four requesters valid
        reset_pulse();
        for (int i = 0; i < N; i++) load(i, 8);
        step(12);
        for (int c = 0; c < 10; c++) begin
            chk($sformatf("B2 xfer c%0d", c + 1), tx[1][c+1], 1);
            chk($sformatf("B2 id c%0d", c + 1), tid[1][c+1], ex_b1[c]);
        end
        for (int c = 0; c < 8; c++)
            chk($sformatf("B1 id c%0d", c + 1), tid[2][c+1], ex_b2[c]);

        // requester 1 runs dry mid-burst while 2 waits
        reset_pulse();
        load(1, 2);
        load(2, 4);
        step(10);
        for (int c = 0; c < 7; c++)
            chk($sformatf("C valid c%0d", c), tv[0][c], ex_cv[c]);
        chk("C release id", tid[0][3], 1);
        chk("C idle id", tid[0][4], 0);
        chk("C regrant id", tid[0][5], 2);

        // backpressure for 5 cycles mid-burst
        reset_pulse();
        load(0, 6);
        step(3);
        mr = 1'b0;
        step(5);
        mr = 1'b1;
        step(8);
        for (int c = 0; c < 13; c++)
            chk($sformatf("D xfer c%0d", c), tx[0][c], ex_d[c]);
        for (int c = 3; c < 8; c++) begin
            chk($sformatf("D held valid c%0d", c), tv[0][c], 1);
            chk($sformatf("D held data c%0d", c), tdat[0][c], 16'h0002);
        end
        chk("D beat5 data", tdat[0][12], 16'h0005);

        // reset during beat 2 of a burst
        reset_pulse();
        load(2, 6);
        step(3);
        rst_n = 1'b0;
        load(1, 3);
        load(3, 3);
        step(1);
        rst_n = 1'b1;
        step(8);
        chk("E reset valid", tv[0][3], 0);
        chk("E reset id", tid[0][3], 0);
        chk("E post idle", tv[0][4], 0);
        chk("E first id", tid[0][5], 1);
        chk("E first data", tdat[0][5], 16'h1000);
        chk("E req2 resumes id", tid[0][10], 2);
        chk("E req2 resumes data", tdat[0][10], 16'h2002);

`ifdef STREAM_RR_ARB_STATS_EN
        // counters on a BURST=255 arbiter fed only by requester 3
        @(posedge clk);
        #1;
        sv_s = 4'b1000;
        repeat (1000) @(posedge clk);
        #1;
        chk("S beats3 c1000", int'(st_s[48 +: 16]), 996);
        repeat (69400) @(posedge clk);
        #1;
        chk("S beats3 sat", int'(st_s[48 +: 16]), 16'hFFFF);
        for (int i = 0; i < 3; i++)
            chk($sformatf("S beats%0d", i), int'(st_s[i*16 +: 16]), 0);
        repeat (5) @(posedge clk);
        #1;
        clr_s = 1'b1;
        @(posedge clk);
        #1;
        clr_s = 1'b0;
        chk("S clr", int'(st_s[48 +: 16]), 0);
        @(posedge clk);
        #1;
        chk("S after clr", int'(st_s[48 +: 16]), 1);
        sv_s = '0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/stream_rr_arb.md
STREAM_RR_ARB -- requirements
Module: stream_rr_arb

Interface
REQ-001 SHALL have parameter W, default 16, data width per beat.
REQ-002 SHALL have parameter N, default 4, number of requesters (2..8).
REQ-003 SHALL have parameter BURST, default 4, max beats per grant (1..255).
REQ-004 SHALL have port clk  input  1  single clock, all logic rising-edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port s_data  input  N*W  requester data, requester i at bits [i*W +: W].
REQ-007 SHALL have port s_valid  input  N  per-requester valid.
REQ-008 SHALL have port s_ready  output  N  per-requester ready.
REQ-009 SHALL have port m_data  output  W  granted data toward the shared FIFO write side.
REQ-010 SHALL have port m_valid  output  1  beat valid toward FIFO.
REQ-011 SHALL have port m_ready  input  1  FIFO not-full.
REQ-012 SHALL have port m_id  output  $clog2(N)  index of the granted requester.

Function
REQ-013 SHALL implement FSM states IDLE and BUSY; reset state IDLE.
REQ-014 In IDLE: m_valid=0, s_ready=0, m_data=0, m_id=0.
REQ-015 In IDLE with any s_valid set: grant = first set bit searching upward from rr_ptr with wrap; next cycle BUSY, beat count 0.
REQ-016 In BUSY: m_valid=s_valid[g], m_data=s_data[g], m_id=g, s_ready[g]=m_ready, every other s_ready=0.
REQ-017 m_valid and m_data SHALL NOT depend combinationally on m_ready.
REQ-018 A beat transfers when m_valid && m_ready; only transfers increment the beat count.
REQ-019 On the transfer that makes count==BURST: rr_ptr<=(g+1) mod N; if some requester other than g is valid, regrant in the same cycle using the REQ-015 search from g+1, stay BUSY, count 0; else IDLE.
REQ-020 Requester g itself is eligible on re-search only when no other requester is valid, and only via IDLE (one-cycle bubble).
REQ-021 In BUSY with s_valid[g]=0: release; next state IDLE, rr_ptr<=(g+1) mod N, no transfer that cycle.
REQ-022 m_ready=0 during BUSY: hold grant, count and outputs; no timeout.
REQ-023 BURST=1: every transfer ends the grant.
REQ-024 Arbitration latency from IDLE: first m_valid one cycle after s_valid seen.

Reset
REQ-025 rst_n low: state IDLE, g=0, count=0, rr_ptr=0, all outputs 0, asynchronously.
REQ-026 Reset mid-burst: burst abandoned; no beat is transferred in the reset cycle.
REQ-027 After rst_n deasserts, the first grant searches from requester 0.

Configuration
REQ-028 Macro STREAM_RR_ARB_STATS_EN defined: add ports stats_clr input 1 and stats_beats output N*16; per-requester 16-bit beat counters increment on each transfer, saturate at 0xFFFF, synchronous clear on stats_clr (clear wins over increment), reset 0.
REQ-029 Macro undefined: stats ports and counters absent; all other behaviour identical.

Structure
REQ-030 Package stream_arb_pkg SHALL hold the FSM state enum typedef and a BEAT_CNT_W=8 constant.
REQ-031 Round-robin search SHALL be sub-module rr_pick: inputs req[N], ptr; outputs any, idx; purely combinational.

Verification
REQ-032 Single requester 0 with 10 continuous beats, BURST=4, m_ready=1 -> beats 0..3, bubble, 4..7, bubble, 8..9; m_id=0 throughout.
REQ-033 All 4 requesters valid continuously, BURST=2 -> m_id sequence 0,0,1,1,2,2,3,3,0,0 with no bubbles.
REQ-034 Requester 1 drops s_valid after 2 of 4 beats while requester 2 is valid -> IDLE one cycle, then grant 2.
REQ-035 m_ready held 0 for 5 cycles mid-burst -> m_data, m_id and count stable, s_ready[g]=0, no lost or duplicated beat.
REQ-036 rst_n pulsed low during beat 2 of a burst -> outputs 0 same cycle; after release first grant goes to the lowest valid index.
REQ-037 With STREAM_RR_ARB_STATS_EN, 70000 beats from requester 3 -> stats_beats[3] = 0xFFFF; stats_clr -> 0 next cycle.
